hermes_input_buffer: RTL and testbench
======================================

HERMES_INPUT_BUFFER -- requirements
Module: hermes_input_buffer

Interface
REQ-001 SHALL have parameter FLIT_SIZE, default 32, flit width in bits, minimum 20.
REQ-002 SHALL have parameter BUFFER_SIZE, default 8, FIFO depth in flits, power of 2, minimum 4.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_i  input  1  upstream flit valid.
REQ-006 SHALL have port data_i  input  FLIT_SIZE  upstream flit.
REQ-007 SHALL have port credit_o  output  1  space available; a flit is accepted when rx_i and credit_o are both high.
REQ-008 SHALL have port req_o  output  1  routing request to the switch control.
REQ-009 SHALL have port ack_i  input  1  routing grant from the switch control, a 1-cycle pulse.
REQ-010 SHALL have port sending_o  output  1  packet in transmission; its falling edge releases the output port in the switch.
REQ-011 SHALL have port tx_o  output  1  flit valid toward the crossbar.
REQ-012 SHALL have port data_o  output  FLIT_SIZE  head flit of the FIFO.
REQ-013 SHALL have port credit_i  input  1  downstream space; a flit is transferred when tx_o and credit_i are both high.

Function
REQ-014 SHALL store flits in a circular FIFO of BUFFER_SIZE entries with head and tail pointers wrapping modulo BUFFER_SIZE.
REQ-015 SHALL track occupancy with a counter of $clog2(BUFFER_SIZE)+1 bits: +1 on write only, -1 on read only, unchanged on a simultaneous read and write.
REQ-016 SHALL drive credit_o = (occupancy < BUFFER_SIZE), so no write occurs when full; a read in the full cycle raises credit_o on the next cycle.
REQ-017 SHALL drive data_o combinationally from the entry at the head pointer; data_o is don't-care while tx_o is low.
REQ-018 SHALL treat packet format as: flit 0 = header (target in [15:0]), flit 1 = size (payload flit count, unsigned FLIT_SIZE bits), followed by size payload flits.
REQ-019 SHALL implement an FSM with states S_IDLE, S_REQ, S_HEADER, S_SIZE and S_PAYLOAD.
REQ-020 In S_IDLE, SHALL go to S_REQ when occupancy > 0.
REQ-021 In S_REQ, SHALL hold req_o = 1 with the header at the head (not read), and go to S_HEADER on the cycle ack_i is sampled high; req_o is 0 in every other state.
REQ-022 In S_HEADER, S_SIZE and S_PAYLOAD, SHALL drive tx_o = (occupancy > 0), and SHALL advance the state only on a transfer (tx_o and credit_i).
REQ-023 On the S_HEADER transfer, SHALL go to S_SIZE.
REQ-024 On the S_SIZE transfer, SHALL load the payload counter with data_o, then go to S_PAYLOAD if data_o != 0, or to S_IDLE if data_o == 0.
REQ-025 In S_PAYLOAD, SHALL decrement the counter on each transfer, and on the transfer with counter == 1 go to S_IDLE.
REQ-026 SHALL drive sending_o = 1 exactly in S_HEADER, S_SIZE and S_PAYLOAD, decoded from registered state.
REQ-027 When a transfer is stalled (credit_i low or FIFO empty), SHALL hold the counter, the head pointer and data_o.
REQ-028 SHALL leave at least one cycle in S_IDLE between consecutive packets; the next header's req_o rises 1 cycle after S_IDLE is entered with occupancy > 0.
REQ-029 SHALL accept upstream writes in all states, independent of the FSM.

Reset
REQ-030 While rst_i is high at a clock edge, SHALL set state = S_IDLE, pointers = 0, occupancy = 0 and counter = 0; FIFO storage is not reset.
REQ-031 Output values after reset: credit_o = 1, req_o = 0, tx_o = 0, sending_o = 0.
REQ-032 Reset mid-packet SHALL discard all buffered flits; sending_o falls on the first edge with rst_i high, and no flit is transferred on that edge.

Verification
REQ-033 Reset: assert rst_i for 2 cycles -> credit_o=1, req_o=0, tx_o=0, sending_o=0.
REQ-034 Basic packet: write 0x00000102, 0x00000002, 0xAAAA0001, 0xBBBB0002 with credit_i=1; pulse ack_i while req_o=1 -> req_o drops, then 4 consecutive transfers in order, sending_o high for exactly those 4 cycles, then S_IDLE.
REQ-035 Full FIFO (BUFFER_SIZE=8): write 9 flits with no ack_i -> credit_o=0 after the 8th write, the 9th flit is not stored, occupancy=8.
REQ-036 Back-pressure: hold credit_i=0 for 3 cycles after the 1st payload flit -> tx_o stays 1, data_o holds the 2nd payload, counter holds at 1, transmission resumes when credit_i=1.
REQ-037 Zero payload: header then size 0x00000000 -> exactly 2 flits transferred, sending_o falls after the size flit, and the next header raises req_o after 1 S_IDLE cycle.
REQ-038 Reset mid-payload: rst_i high during S_PAYLOAD -> sending_o=0, occupancy=0, credit_o=1 on the next cycle.

Source files
------------

// File: rtl/hermes_input_buffer.sv
// hermes_input_buffer: Hermes NoC input buffer, a circular FIFO plus a packet FSM
// that asks the switch control for a route and then streams one packet.
//   clk_i, rst_i          clock, synchronous active-high reset
//   rx_i, data_i          upstream flit valid and flit
//   credit_o              space available upstream (occupancy < BUFFER_SIZE)
//   req_o, ack_i          routing request and its one-cycle grant
//   sending_o             packet in transmission; its falling edge frees the output port
//   tx_o, data_o          flit valid and head flit toward the crossbar
//   credit_i              downstream space
module hermes_input_buffer #(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 credit_o,
    output logic                 req_o,
    input  logic                 ack_i,
    output logic                 sending_o,
    output logic                 tx_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 credit_i
);
    localparam int PW = $clog2(BUFFER_SIZE);
    localparam logic [PW:0] DEPTH = (PW+1)'(BUFFER_SIZE);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_HEADER, S_SIZE, S_PAYLOAD} state_t;

    state_t               state_q, state_d;
    logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
    logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [PW:0]          occ_q, occ_d;
    logic [FLIT_SIZE-1:0] cnt_q, cnt_d;
    logic                 wr, rd;

    assign credit_o  = occ_q < DEPTH;
    assign req_o     = state_q == S_REQ;
    assign sending_o = state_q inside {S_HEADER, S_SIZE, S_PAYLOAD};
    assign tx_o      = sending_o && occ_q != '0;
    assign data_o    = mem_q[head_q];
    assign wr        = rx_i && credit_o;
    assign rd        = tx_o && credit_i;

    always_comb begin
        head_d  = head_q + PW'(rd);
        tail_d  = tail_q + PW'(wr);
        occ_d   = occ_q + (PW+1)'(wr) - (PW+1)'(rd);
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (occ_q != '0) state_d = S_REQ;
            S_REQ:    if (ack_i) state_d = S_HEADER;
            S_HEADER: if (rd) state_d = S_SIZE;
            S_SIZE: if (rd) begin
                cnt_d   = data_o;
                state_d = data_o != '0 ? S_PAYLOAD : S_IDLE;
            end
            S_PAYLOAD: if (rd) begin
                cnt_d   = cnt_q - FLIT_SIZE'(1);
                state_d = cnt_q == FLIT_SIZE'(1) ? S_IDLE : S_PAYLOAD;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[tail_q] <= data_i;
    end
endmodule

// File: tb/tb_hermes_input_buffer.sv
// tb_hermes_input_buffer: directed self-checking bench for hermes_input_buffer.
module tb_hermes_input_buffer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        credit_o;
    logic        req_o;
    logic        ack_i = 1'b0;
    logic        sending_o;
    logic        tx_o;
    logic [31:0] data_o;
    logic        credit_i = 1'b1;
    int          total = 0;
    int          passed = 0;

    hermes_input_buffer #(.FLIT_SIZE(32), .BUFFER_SIZE(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .data_i(data_i),
        .credit_o(credit_o), .req_o(req_o), .ack_i(ack_i), .sending_o(sending_o),
        .tx_o(tx_o), .data_o(data_o), .credit_i(credit_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic put(input logic [31:0] d);
        rx_i = 1'b1;
        data_i = d;
        tick();
        rx_i = 1'b0;
    endtask

    task automatic grant;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        total++; if (credit_o !== 1'b1) $display("FAIL reset_credit got %b want 1", credit_o); else passed++;
        total++; if (req_o !== 1'b0) $display("FAIL reset_req got %b want 0", req_o); else passed++;
        total++; if (tx_o !== 1'b0) $display("FAIL reset_tx got %b want 0", tx_o); else passed++;
        total++; if (sending_o !== 1'b0) $display("FAIL reset_sending got %b want 0", sending_o); else passed++;
    endtask

    task automatic test_basic;
        logic [31:0] f [4];
        f = '{32'h00000102, 32'h00000002, 32'hAAAA0001, 32'hBBBB0002};
        credit_i = 1'b1;
        for (int i = 0; i < 4; i++) put(f[i]);
        total++; if (req_o !== 1'b1) $display("FAIL basic_req got %b want 1", req_o); else passed++;
        total++; if (tx_o !== 1'b0) $display("FAIL basic_tx_before_ack got %b want 0", tx_o); else passed++;
        grant();
        total++; if (req_o !== 1'b0) $display("FAIL basic_req_drop got %b want 0", req_o); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (tx_o !== 1'b1) $display("FAIL basic_tx[%0d] got %b want 1", i, tx_o); else passed++;
            total++; if (sending_o !== 1'b1) $display("FAIL basic_sending[%0d] got %b want 1", i, sending_o); else passed++;
            total++; if (data_o !== f[i]) $display("FAIL basic_data[%0d] got %h want %h", i, data_o, f[i]); else passed++;
            tick();
        end
        total++; if (sending_o !== 1'b0) $display("FAIL basic_sending_end got %b want 0", sending_o); else passed++;
        total++; if (tx_o !== 1'b0) $display("FAIL basic_tx_end got %b want 0", tx_o); else passed++;
        tick();
        total++; if (req_o !== 1'b0) $display("FAIL basic_idle_req got %b want 0", req_o); else passed++;
    endtask

    task automatic test_full;
        logic [31:0] f [8];
        f[0] = 32'h00000203;
        f[1] = 32'h00000006;
        for (int i = 0; i < 6; i++) f[i+2] = 32'h11110000 + i;
        credit_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put(f[i]);
            if (i == 6) begin
                total++; if (credit_o !== 1'b1) $display("FAIL full_credit_7 got %b want 1", credit_o); else passed++;
            end
        end
        total++; if (credit_o !== 1'b0) $display("FAIL full_credit_8 got %b want 0", credit_o); else passed++;
        put(32'hDEADBEEF);
        total++; if (credit_o !== 1'b0) $display("FAIL full_credit_9 got %b want 0", credit_o); else passed++;
        grant();
        for (int i = 0; i < 8; i++) begin
            total++; if (tx_o !== 1'b1) $display("FAIL full_tx[%0d] got %b want 1", i, tx_o); else passed++;
            total++; if (data_o !== f[i]) $display("FAIL full_data[%0d] got %h want %h", i, data_o, f[i]); else passed++;
            tick();
            if (i == 0) begin
                total++; if (credit_o !== 1'b1) $display("FAIL full_credit_after_read got %b want 1", credit_o); else passed++;
            end
        end
        total++; if (sending_o !== 1'b0) $display("FAIL full_sending_end got %b want 0", sending_o); else passed++;
        total++; if (tx_o !== 1'b0) $display("FAIL full_tx_end got %b want 0", tx_o); else passed++;
        tick();
        tick();
        total++; if (req_o !== 1'b0) $display("FAIL full_ninth_dropped req got %b want 0", req_o); else passed++;
    endtask

    task automatic test_backpressure;
        credit_i = 1'b1;
        put(32'h00000304);
        put(32'h00000002);
        put(32'hAAAA0011);
        put(32'hBBBB0022);
        grant();
        tick();
        tick();
        tick();
        credit_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (tx_o !== 1'b1) $display("FAIL bp_tx[%0d] got %b want 1", i, tx_o); else passed++;
            total++; if (sending_o !== 1'b1) $display("FAIL bp_sending[%0d] got %b want 1", i, sending_o); else passed++;
            total++; if (data_o !== 32'hBBBB0022) $display("FAIL bp_data[%0d] got %h want bbbb0022", i, data_o); else passed++;
            tick();
        end
        credit_i = 1'b1;
        total++; if (data_o !== 32'hBBBB0022) $display("FAIL bp_resume_data got %h want bbbb0022", data_o); else passed++;
        tick();
        total++; if (sending_o !== 1'b0) $display("FAIL bp_sending_end got %b want 0", sending_o); else passed++;
        total++; if (tx_o !== 1'b0) $display("FAIL bp_tx_end got %b want 0", tx_o); else passed++;
    endtask

    task automatic test_zero_payload;
        credit_i = 1'b1;
        put(32'h00000405);
        put(32'h00000000);
        put(32'h00000506);
        put(32'h00000000);
        grant();
        total++; if (data_o !== 32'h00000405) $display("FAIL zero_hdr got %h want 00000405", data_o); else passed++;
        tick();
        total++; if (data_o !== 32'h00000000) $display("FAIL zero_size got %h want 00000000", data_o); else passed++;
        total++; if (sending_o !== 1'b1) $display("FAIL zero_sending_size got %b want 1", sending_o); else passed++;
        tick();
        total++; if (sending_o !== 1'b0) $display("FAIL zero_sending_end got %b want 0", sending_o); else passed++;
        total++; if (req_o !== 1'b0) $display("FAIL zero_idle_req got %b want 0", req_o); else passed++;
        total++; if (tx_o !== 1'b0) $display("FAIL zero_idle_tx got %b want 0", tx_o); else passed++;
        tick();
        total++; if (req_o !== 1'b1) $display("FAIL zero_next_req got %b want 1", req_o); else passed++;
        total++; if (data_o !== 32'h00000506) $display("FAIL zero_next_hdr got %h want 00000506", data_o); else passed++;
        grant();
        tick();
        tick();
        total++; if (sending_o !== 1'b0) $display("FAIL zero_second_end got %b want 0", sending_o); else passed++;
        tick();
        total++; if (req_o !== 1'b0) $display("FAIL zero_drained_req got %b want 0", req_o); else passed++;
    endtask

    task automatic test_mid_reset;
        credit_i = 1'b1;
        put(32'h00000607);
        put(32'h00000004);
        for (int i = 0; i < 4; i++) put(32'hCCCC0000 + i);
        grant();
        tick();
        tick();
        tick();
        total++; if (sending_o !== 1'b1) $display("FAIL mr_sending_before got %b want 1", sending_o); else passed++;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total++; if (sending_o !== 1'b0) $display("FAIL mr_sending got %b want 0", sending_o); else passed++;
        total++; if (credit_o !== 1'b1) $display("FAIL mr_credit got %b want 1", credit_o); else passed++;
        total++; if (tx_o !== 1'b0) $display("FAIL mr_tx got %b want 0", tx_o); else passed++;
        tick();
        tick();
        total++; if (req_o !== 1'b0) $display("FAIL mr_empty_req got %b want 0", req_o); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_backpressure();
        test_zero_payload();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
